mega_axi_rd_arbiter: RTL and testbench

//  Parametrised N-port AXI read-channel arbiter placed between core-side read requesters (ICache, DCache,

---
 rtl/mega_axi_rd_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_mega_axi_rd_arbiter.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mega_axi_rd_arbiter.sv
// rtl/mega_axi_rd_arbiter.sv - N-port round-robin AXI read-channel arbiter with per-port outstanding limit
module mega_axi_rd_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ID_W      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUT   = 4
) (
    input  logic                          aclk,
    input  logic                          areset,
    // requester side, AR
    input  logic [NUM_PORTS-1:0]          p_arvalid,
    output logic [NUM_PORTS-1:0]          p_arready,
    input  logic [NUM_PORTS*ADDR_W-1:0]   p_araddr,
    input  logic [NUM_PORTS*8-1:0]        p_arlen,
    input  logic [NUM_PORTS*3-1:0]        p_arsize,
    input  logic [NUM_PORTS*2-1:0]        p_arburst,
    // requester side, R
    output logic [NUM_PORTS-1:0]          p_rvalid,
    input  logic [NUM_PORTS-1:0]          p_rready,
    output logic [DATA_W-1:0]             p_rdata,
    output logic [1:0]                    p_rresp,
    output logic                          p_rlast,
    // AXI master, AR
    output logic [ID_W-1:0]               arid,
    output logic [ADDR_W-1:0]             araddr,
    output logic [7:0]                    arlen,
    output logic [2:0]                    arsize,
    output logic [1:0]                    arburst,
    output logic [1:0]                    arlock,
    output logic [3:0]                    arcache,
    output logic [2:0]                    arprot,
    output logic                          arvalid,
    input  logic                          arready,
    // AXI master, R
    input  logic [ID_W-1:0]               rid,
    input  logic [DATA_W-1:0]             rdata,
    input  logic [1:0]                    rresp,
    input  logic                          rlast,
    input  logic                          rvalid,
    output logic                          rready,
    output logic                          err_bad_rid
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_OUT);
    localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(NUM_PORTS - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PTR_W-1:0]      r_rr_ptr;
    logic [PTR_W-1:0]      r_grant;
    logic [PTR_W-1:0]      w_winner;
    logic                  w_found;
    logic [NUM_PORTS-1:0]  w_eligible;
    logic [CNT_W-1:0]      r_cnt [NUM_PORTS];
    logic [NUM_PORTS-1:0]  w_inc;
    logic [NUM_PORTS-1:0]  w_dec;
    logic                  r_arvalid;
    logic [ADDR_W-1:0]     r_araddr;
    logic [7:0]            r_arlen;
    logic [2:0]            r_arsize;
    logic [1:0]            r_arburst;
    logic                  r_err;
    logic                  w_rid_ok;
    logic                  w_ar_hs;
    logic                  w_r_last_hs;
    logic                  w_grant_now;

    // A port may compete only while it is below its outstanding-burst limit
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_eligible[i] = p_arvalid[i] & (r_cnt[i] != CNT_MAX);
        end
    end

    // Round-robin pick: first eligible port at or after r_rr_ptr; scanning downward lets the nearest one win
    always_comb begin
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (w_eligible[idx]) begin
                w_found  = 1'b1;
                w_winner = PTR_W'(idx);
            end
        end
    end

    // AR FSM state register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // AR FSM next state and the combinational requester-side accept
    always_comb begin
        w_state_nxt = r_state;
        p_arready   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    p_arready[w_winner] = 1'b1;
                    w_state_nxt         = S_HOLD;
                end
            end
            S_HOLD: begin
                if (arready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_grant_now = (r_state == S_IDLE) & w_found;
    assign w_ar_hs     = r_arvalid & arready;

    // AR payload capture on grant; held stable until the AXI handshake, which also advances the pointer
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_arburst <= '0;
            r_grant   <= '0;
            r_rr_ptr  <= '0;
        end else if (w_grant_now) begin
            r_arvalid <= 1'b1;
            r_araddr  <= p_araddr[int'(w_winner)*ADDR_W +: ADDR_W];
            r_arlen   <= p_arlen[int'(w_winner)*8 +: 8];
            r_arsize  <= p_arsize[int'(w_winner)*3 +: 3];
            r_arburst <= p_arburst[int'(w_winner)*2 +: 2];
            r_grant   <= w_winner;
        end else if ((r_state == S_HOLD) && arready) begin
            r_arvalid <= 1'b0;
            r_rr_ptr  <= (r_grant == LAST_PORT) ? '0 : r_grant + PTR_W'(1);
        end
    end

    assign w_r_last_hs = rvalid & rready & rlast;

    // Per-port burst start/finish events for the outstanding counters
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_inc[i] = w_ar_hs & (r_grant == PTR_W'(i));
            w_dec[i] = w_r_last_hs & (rid == ID_W'(i));
        end
    end

    // Outstanding counters: simultaneous start and finish cancel, a stray last beat never underflows
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0)) begin
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    // R routing by rid; unknown ids are swallowed by holding rready high
    always_comb begin
        p_rvalid = '0;
        rready   = 1'b1;
        w_rid_ok = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (rid == ID_W'(i)) begin
                p_rvalid[i] = rvalid;
                rready      = p_rready[i];
                w_rid_ok    = 1'b1;
            end
        end
    end

    // Sticky flag for any beat carrying an id no port owns
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_err <= 1'b0;
        end else if (rvalid && !w_rid_ok) begin
            r_err <= 1'b1;
        end
    end

    assign arvalid     = r_arvalid;
    assign arid        = ID_W'(r_grant);
    assign araddr      = r_araddr;
    assign arlen       = r_arlen;
    assign arsize      = r_arsize;
    assign arburst     = r_arburst;
    assign arlock      = 2'b00;
    assign arcache     = 4'b0000;
    assign arprot      = 3'b000;
    assign p_rdata     = rdata;
    assign p_rresp     = rresp;
    assign p_rlast     = rlast;
    assign err_bad_rid = r_err;

endmodule

// File: tb/tb_mega_axi_rd_arbiter.sv
// tb/tb_mega_axi_rd_arbiter.sv - randomized self-checking bench for mega_axi_rd_arbiter
module tb_mega_axi_rd_arbiter;

    localparam int NP  = 2;
    localparam int IDW = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MO  = 4;

    logic              aclk;
    logic              areset;
    logic [NP-1:0]     p_arvalid;
    logic [NP-1:0]     p_arready;
    logic [NP*AW-1:0]  p_araddr;
    logic [NP*8-1:0]   p_arlen;
    logic [NP*3-1:0]   p_arsize;
    logic [NP*2-1:0]   p_arburst;
    logic [NP-1:0]     p_rvalid;
    logic [NP-1:0]     p_rready;
    logic [DW-1:0]     p_rdata;
    logic [1:0]        p_rresp;
    logic              p_rlast;
    logic [IDW-1:0]    arid;
    logic [AW-1:0]     araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [1:0]        arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [IDW-1:0]    rid;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    logic              err_bad_rid;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int          m_cnt [NP];
    int          m_ptr;
    bit          m_pend;
    int          m_id;
    logic [AW-1:0] m_addr;
    logic [7:0]  m_len;
    logic [2:0]  m_size;
    logic [1:0]  m_burst;
    bit          m_err;

    mega_axi_rd_arbiter #(
        .NUM_PORTS(NP), .ID_W(IDW), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)
    ) dut (
        .aclk(aclk), .areset(areset),
        .p_arvalid(p_arvalid), .p_arready(p_arready), .p_araddr(p_araddr),
        .p_arlen(p_arlen), .p_arsize(p_arsize), .p_arburst(p_arburst),
        .p_rvalid(p_rvalid), .p_rready(p_rready), .p_rdata(p_rdata),
        .p_rresp(p_rresp), .p_rlast(p_rlast),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready), .err_bad_rid(err_bad_rid)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic int exp_winner();
        int idx;
        if (m_pend) return -1;
        for (int k = 0; k < NP; k++) begin
            idx = (m_ptr + k) % NP;
            if (p_arvalid[idx] && (m_cnt[idx] != MO)) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NP-1:0] exp_arready();
        int w;
        logic [NP-1:0] v;
        w = exp_winner();
        v = '0;
        if (w >= 0) v[w] = 1'b1;
        return v;
    endfunction

    function automatic logic exp_rready();
        if (int'(rid) < NP) return p_rready[rid];
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) m_cnt[i] = 0;
        m_ptr  = 0;
        m_pend = 0;
        m_id   = 0;
        m_err  = 0;
    endtask

    // advance one clock and apply the specified rules to the model
    task automatic tick();
        int w;
        bit hs;
        bit inc [NP];
        bit dec [NP];
        logic [AW-1:0] a;
        logic [7:0] l;
        logic [2:0] s;
        logic [1:0] b;
        w  = exp_winner();
        hs = m_pend && arready;
        for (int i = 0; i < NP; i++) begin
            inc[i] = hs && (m_id == i);
            dec[i] = rvalid && exp_rready() && rlast && (int'(rid) == i);
        end
        if (w >= 0) begin
            a = p_araddr[w*AW +: AW];
            l = p_arlen[w*8 +: 8];
            s = p_arsize[w*3 +: 3];
            b = p_arburst[w*2 +: 2];
        end
        if (rvalid && int'(rid) >= NP) m_err = 1;
        @(posedge aclk);
        if (hs) begin
            m_pend = 0;
            m_ptr  = (m_id + 1) % NP;
        end else if (w >= 0) begin
            m_pend  = 1;
            m_id    = w;
            m_addr  = a;
            m_len   = l;
            m_size  = s;
            m_burst = b;
        end
        for (int i = 0; i < NP; i++) begin
            if (inc[i] && !dec[i]) m_cnt[i]++;
            else if (dec[i] && !inc[i] && m_cnt[i] > 0) m_cnt[i]--;
        end
        #1;
    endtask

    task automatic do_reset();
        p_arvalid = '0;
        rvalid    = 1'b0;
        arready   = 1'b0;
        rlast     = 1'b0;
        areset    = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        areset    = 1'b1;
        p_arvalid = '0; p_araddr = '0; p_arlen = '0; p_arsize = '0; p_arburst = '0;
        p_rready  = '0; arready = 1'b0; rid = '0; rdata = '0; rresp = '0;
        rlast     = 1'b0; rvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        n_tests++;
        if (arvalid !== 1'b0 || araddr !== '0 || arid !== '0 || arlen !== '0) begin
            n_fail++;
            $display("FAIL reset_ar: arvalid=%b araddr=%h arid=%h arlen=%h expected all 0", arvalid, araddr, arid, arlen);
        end
        n_tests++;
        if (p_arready !== '0 || err_bad_rid !== 1'b0 || {arlock, arcache, arprot} !== '0) begin
            n_fail++;
            $display("FAIL reset_misc: p_arready=%b err=%b const=%h expected 0", p_arready, err_bad_rid, {arlock, arcache, arprot});
        end
        areset = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        logic [DW-1:0] d;
        do_reset();
        p_arvalid = 2'b01;
        p_araddr[0 +: AW] = 32'h1C00_0000;
        p_arlen[0 +: 8]   = 8'd3;
        p_arsize[0 +: 3]  = 3'd2;
        p_arburst[0 +: 2] = 2'd1;
        #1;
        n_tests++;
        if (p_arready !== 2'b01) begin
            n_fail++; $display("FAIL single_parready: got %b expected 01", p_arready);
        end
        tick();
        p_arvalid = '0;
        #1;
        n_tests++;
        if (arvalid !== 1'b1 || arid !== 4'd0 || araddr !== 32'h1C00_0000 || arlen !== 8'd3
            || arsize !== 3'd2 || arburst !== 2'd1) begin
            n_fail++;
            $display("FAIL single_ar: arvalid=%b arid=%h araddr=%h arlen=%h expected 1 0 1c000000 3", arvalid, arid, araddr, arlen);
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        #1;
        n_tests++;
        if (arvalid !== 1'b0) begin
            n_fail++; $display("FAIL single_ar_drop: arvalid=%b expected 0", arvalid);
        end
        for (int b = 0; b < 4; b++) begin
            d = $urandom;
            rvalid = 1'b1; rid = 4'd0; rdata = d; rresp = 2'b00;
            rlast = (b == 3); p_rready = 2'b01;
            #1;
            n_tests++;
            if (p_rvalid !== 2'b01 || rready !== 1'b1 || p_rdata !== d || p_rlast !== (b == 3)) begin
                n_fail++;
                $display("FAIL single_beat%0d: p_rvalid=%b rready=%b p_rdata=%h p_rlast=%b expected 01 1 %h %b",
                         b, p_rvalid, rready, p_rdata, p_rlast, d, (b == 3));
            end
            tick();
        end
        rvalid = 1'b0; rlast = 1'b0; p_rready = '0;
    endtask

    task automatic test_contention();
        int ids[$];
        int cyc[$];
        do_reset();
        p_arvalid = 2'b11;
        arready   = 1'b1;
        for (int c = 0; c < 9; c++) begin
            #1;
            n_tests++;
            if (p_arready !== exp_arready()) begin
                n_fail++; $display("FAIL contention_parready c%0d: got %b expected %b", c, p_arready, exp_arready());
            end
            if (arvalid) begin
                ids.push_back(int'(arid));
                cyc.push_back(c);
            end
            tick();
        end
        p_arvalid = '0;
        arready   = 1'b0;
        n_tests++;
        if (ids.size() != 4) begin
            n_fail++; $display("FAIL contention_count: got %0d ARs expected 4", ids.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_tests++;
                if (ids[k] != (k % 2)) begin
                    n_fail++; $display("FAIL contention_order%0d: got id %0d expected %0d", k, ids[k], k % 2);
                end
                if (k > 0) begin
                    n_tests++;
                    if (cyc[k] - cyc[k-1] != 2) begin
                        n_fail++; $display("FAIL contention_spacing%0d: got %0d cycles expected 2", k, cyc[k] - cyc[k-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_limit();
        int cnt;
        do_reset();
        p_arvalid = 2'b01;
        p_araddr  = {$urandom, $urandom};
        arready   = 1'b1;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (arvalid) cnt++;
            tick();
        end
        #1;
        n_tests++;
        if (cnt != MO) begin
            n_fail++; $display("FAIL limit_count: got %0d ARs expected %0d", cnt, MO);
        end
        n_tests++;
        if (p_arready !== 2'b00 || arvalid !== 1'b0) begin
            n_fail++; $display("FAIL limit_block: p_arready=%b arvalid=%b expected 00 0", p_arready, arvalid);
        end
        rvalid = 1'b1; rid = 4'd0; rlast = 1'b1; p_rready = 2'b01;
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (arvalid) cnt++;
            tick();
        end
        n_tests++;
        if (cnt != 1) begin
            n_fail++; $display("FAIL limit_release: got %0d ARs expected 1", cnt);
        end
        p_arvalid = '0;
        arready   = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] a;
        a = $urandom;
        do_reset();
        p_arvalid = 2'b10;
        p_araddr[AW +: AW] = a;
        p_arlen[8 +: 8]    = 8'd7;
        #1;
        n_tests++;
        if (p_arready !== 2'b10) begin
            n_fail++; $display("FAIL bp_parready: got %b expected 10", p_arready);
        end
        tick();
        p_arvalid = 2'b11;
        p_araddr  = {~a, $urandom};
        arready   = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_tests++;
            if (arvalid !== 1'b1 || araddr !== a || arlen !== 8'd7 || arid !== 4'd1 || p_arready !== 2'b00) begin
                n_fail++;
                $display("FAIL bp_hold%0d: arvalid=%b araddr=%h arlen=%h arid=%h p_arready=%b expected 1 %h 07 1 00",
                         c, arvalid, araddr, arlen, arid, p_arready, a);
            end
            tick();
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        #1;
        n_tests++;
        if (arvalid !== 1'b0 || p_arready !== 2'b01) begin
            n_fail++; $display("FAIL bp_release: arvalid=%b p_arready=%b expected 0 01", arvalid, p_arready);
        end
        p_arvalid = '0;
    endtask

    task automatic test_bad_id();
        do_reset();
        rvalid = 1'b1; rid = 4'd3; rlast = 1'b1; p_rready = 2'b00;
        #1;
        n_tests++;
        if (rready !== 1'b1 || p_rvalid !== 2'b00 || err_bad_rid !== 1'b0) begin
            n_fail++; $display("FAIL badid_route: rready=%b p_rvalid=%b err=%b expected 1 00 0", rready, p_rvalid, err_bad_rid);
        end
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (err_bad_rid !== 1'b1) begin
            n_fail++; $display("FAIL badid_sticky: err=%b expected 1", err_bad_rid);
        end
        do_reset();
        n_tests++;
        if (err_bad_rid !== 1'b0) begin
            n_fail++; $display("FAIL badid_clear: err=%b expected 0", err_bad_rid);
        end
    endtask

    task automatic test_reset_hold();
        int cnt;
        do_reset();
        p_arvalid = 2'b10;
        arready   = 1'b1;
        repeat (4) tick();
        arready = 1'b0;
        tick();
        #1;
        n_tests++;
        if (arvalid !== 1'b1 || m_cnt[1] != 2) begin
            n_fail++; $display("FAIL rsthold_setup: arvalid=%b expected 1 with 2 outstanding", arvalid);
        end
        areset = 1'b1;
        #1;
        n_tests++;
        if (arvalid !== 1'b0) begin
            n_fail++; $display("FAIL rsthold_async: arvalid=%b expected 0", arvalid);
        end
        @(posedge aclk);
        #1;
        areset = 1'b0;
        model_reset();
        p_arvalid = 2'b11;
        #1;
        n_tests++;
        if (p_arready !== 2'b01) begin
            n_fail++; $display("FAIL rsthold_ptr: p_arready=%b expected 01", p_arready);
        end
        p_arvalid = 2'b10;
        arready   = 1'b1;
        cnt = 0;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (arvalid) cnt++;
            tick();
        end
        n_tests++;
        if (cnt != MO) begin
            n_fail++; $display("FAIL rsthold_cnt: got %0d ARs expected %0d", cnt, MO);
        end
        p_arvalid = '0;
        arready   = 1'b0;
    endtask

    task automatic test_random();
        logic [NP-1:0] erv;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            p_arvalid = NP'($urandom);
            p_araddr  = {$urandom, $urandom};
            p_arlen   = 16'($urandom);
            p_arsize  = 6'($urandom);
            p_arburst = 4'($urandom);
            arready   = 1'($urandom);
            rvalid    = ($urandom_range(0, 2) != 0);
            rid       = ($urandom_range(0, 9) == 0) ? IDW'($urandom_range(2, 3)) : IDW'($urandom_range(0, 1));
            rlast     = 1'($urandom);
            rdata     = $urandom;
            rresp     = 2'($urandom);
            p_rready  = NP'($urandom);
            #1;
            erv = '0;
            for (int i = 0; i < NP; i++) erv[i] = rvalid && (int'(rid) == i);
            n_tests++;
            if (p_arready !== exp_arready()) begin
                n_fail++; $display("FAIL rand_parready c%0d: got %b expected %b", c, p_arready, exp_arready());
            end
            n_tests++;
            if (arvalid !== m_pend || (m_pend && (arid !== IDW'(m_id) || araddr !== m_addr
                || arlen !== m_len || arsize !== m_size || arburst !== m_burst))) begin
                n_fail++;
                $display("FAIL rand_ar c%0d: arvalid=%b arid=%h araddr=%h arlen=%h expected %b %h %h %h",
                         c, arvalid, arid, araddr, arlen, m_pend, m_id, m_addr, m_len);
            end
            n_tests++;
            if (p_rvalid !== erv || rready !== exp_rready() || p_rdata !== rdata
                || p_rresp !== rresp || p_rlast !== rlast) begin
                n_fail++;
                $display("FAIL rand_r c%0d: p_rvalid=%b rready=%b expected %b %b", c, p_rvalid, rready, erv, exp_rready());
            end
            n_tests++;
            if (err_bad_rid !== m_err) begin
                n_fail++; $display("FAIL rand_err c%0d: got %b expected %b", c, err_bad_rid, m_err);
            end
            tick();
        end
        p_arvalid = '0;
        rvalid    = 1'b0;
        arready   = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_limit();
        test_backpressure();
        test_bad_id();
        test_reset_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
